// File: rtl/adc_ltc2308_scan_sched_if.sv
// Signal bundle between the scan scheduler, its control registers, the adc_ltc2308 core and the sample FIFO.
// The slave modport is the scheduler; the master modport is everything around it.
interface adc_ltc2308_scan_sched_if #(
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 12
);
  logic                cfg_start;
  logic                cfg_abort;
  logic [7:0]          cfg_ch_mask;
  logic [PERIOD_W-1:0] cfg_period;
  logic [CNT_W-1:0]    cfg_scan_num;
  logic                DEC;
  logic                measure_start;
  logic [2:0]          measure_ch;
  logic                measure_done;
  logic [11:0]         measure_dataread;
  // Sample stream: smp_valid rises with data/ch/blank and holds them unchanged until a cycle
  // with smp_valid & smp_ready, which is the single transfer; valid never depends on ready.
  logic                smp_valid;
  logic                smp_ready;
  logic [11:0]         smp_data;
  logic [2:0]          smp_ch;
  logic                smp_blank;
  logic                busy;
  logic                scan_done;
  logic                err_timeout;
  logic [2:0]          dbg_state;

  modport slave (
    input  cfg_start, cfg_abort, cfg_ch_mask, cfg_period, cfg_scan_num, DEC,
    input  measure_done, measure_dataread, smp_ready,
    output measure_start, measure_ch, smp_valid, smp_data, smp_ch, smp_blank,
    output busy, scan_done, err_timeout, dbg_state
  );

  modport master (
    output cfg_start, cfg_abort, cfg_ch_mask, cfg_period, cfg_scan_num, DEC,
    output measure_done, measure_dataread, smp_ready,
    input  measure_start, measure_ch, smp_valid, smp_data, smp_ch, smp_blank,
    input  busy, scan_done, err_timeout, dbg_state
  );
endinterface

// File: rtl/adc_ltc2308_scan_sched.sv
// Multi-channel scan scheduler for the adc_ltc2308 core: paces conversions, tracks the one-deep channel
// pipeline and streams channel-tagged samples. Define ADC_SCAN_DEC_BLANK_EN to enable DEC blanking.
module adc_ltc2308_scan_sched #(
  parameter int          PERIOD_W    = 16,
  parameter int          CNT_W       = 12,
  parameter logic [11:0] BLANK_VALUE = 12'd400,
  parameter int          DONE_TMO    = 1023
) (
  input  logic                     adc_clk,
  input  logic                     adc_reset,
  adc_ltc2308_scan_sched_if.slave  bus
);

  localparam int TMO_W = $clog2(DONE_TMO + 1);

`ifdef ADC_SCAN_DEC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_GAP   = 3'd4,
    S_START = 3'd5
  } state_t;

  state_t              state_q;
  logic [7:0]          mask_q;
  logic [PERIOD_W-1:0] period_q;
  logic [CNT_W-1:0]    scan_num_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PERIOD_W-1:0] per_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                done_prev_q;
  logic                prime_q;
  logic                dec_q;
  logic [2:0]          tag_q;
  logic                measure_start_q;
  logic [2:0]          measure_ch_q;
  logic                smp_valid_q;
  logic [11:0]         smp_data_q;
  logic [2:0]          smp_ch_q;
  logic                smp_blank_q;
  logic                scan_done_q;
  logic                err_q;

  logic                done_edge;
  logic                dec_in;
  logic [PERIOD_W:0]   per_next;
  logic                period_ok;
  logic                count_hit;

  // Next enabled channel strictly after cur, wrapping; returns cur when it is the only one.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] res;
    logic       found;
    logic [2:0] c;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = cur + 3'(i);
      if (!found && mask[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign done_edge = bus.measure_done & ~done_prev_q;
  assign dec_in    = BLANK_EN & bus.DEC;
  // per_q counts cycles since the last start, so a start issued next cycle is per_q+1 apart.
  assign per_next  = {1'b0, per_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign period_ok = per_next >= {1'b0, period_q};
  assign count_hit = (scan_num_q != '0) && (cnt_q == scan_num_q);

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      state_q         <= S_IDLE;
      mask_q          <= '0;
      period_q        <= '0;
      scan_num_q      <= '0;
      cnt_q           <= '0;
      per_q           <= '0;
      tmo_q           <= '0;
      done_prev_q     <= 1'b0;
      prime_q         <= 1'b0;
      dec_q           <= 1'b0;
      tag_q           <= '0;
      measure_start_q <= 1'b0;
      measure_ch_q    <= '0;
      smp_valid_q     <= 1'b0;
      smp_data_q      <= '0;
      smp_ch_q        <= '0;
      smp_blank_q     <= 1'b0;
      scan_done_q     <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_prev_q     <= bus.measure_done;
      measure_start_q <= 1'b0;
      scan_done_q     <= 1'b0;
      if (per_q != '1) per_q <= per_q + PERIOD_W'(1);

      if (bus.cfg_abort) begin
        state_q     <= S_IDLE;
        smp_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.cfg_start) begin
              if (bus.cfg_ch_mask != 8'h00) begin
                mask_q          <= bus.cfg_ch_mask;
                period_q        <= bus.cfg_period;
                scan_num_q      <= bus.cfg_scan_num;
                cnt_q           <= '0;
                err_q           <= 1'b0;
                prime_q         <= 1'b1;
                measure_start_q <= 1'b1;
                measure_ch_q    <= next_ch(bus.cfg_ch_mask, 3'd7);
                per_q           <= '0;
                state_q         <= S_PRIME;
              end else begin
                scan_done_q <= 1'b1;
              end
            end
          end
          S_PRIME, S_START: begin
            dec_q   <= dec_in;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (done_edge) begin
              if (prime_q) begin
                prime_q <= 1'b0;
                state_q <= S_GAP;
              end else begin
                smp_valid_q <= 1'b1;
                smp_data_q  <= dec_q ? BLANK_VALUE : bus.measure_dataread;
                smp_ch_q    <= tag_q;
                smp_blank_q <= dec_q;
                state_q     <= S_PUSH;
              end
            end else if (tmo_q == TMO_W'(DONE_TMO - 1)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_PUSH: begin
            if (bus.smp_ready) begin
              smp_valid_q <= 1'b0;
              cnt_q       <= cnt_q + CNT_W'(1);
              state_q     <= S_GAP;
            end
          end
          S_GAP: begin
            if (count_hit) begin
              scan_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end else if (period_ok) begin
              // The channel programmed one start ago is the one this new conversion samples.
              measure_start_q <= 1'b1;
              measure_ch_q    <= next_ch(mask_q, measure_ch_q);
              tag_q           <= measure_ch_q;
              per_q           <= '0;
              state_q         <= S_START;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.measure_start = measure_start_q;
  assign bus.measure_ch    = measure_ch_q;
  assign bus.smp_valid     = smp_valid_q;
  assign bus.smp_data      = smp_data_q;
  assign bus.smp_ch        = smp_ch_q;
  assign bus.smp_blank     = smp_blank_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.scan_done     = scan_done_q;
  assign bus.err_timeout   = err_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_adc_ltc2308_scan_sched.sv
// Directed bench for adc_ltc2308_scan_sched with an LTC2308 core model and a scan-level expectation model.
`timescale 1ns/1ps
module tb_adc_ltc2308_scan_sched;

`ifdef ADC_SCAN_DEC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic adc_clk = 1'b0;
  logic adc_reset;
  adc_ltc2308_scan_sched_if bus();

  adc_ltc2308_scan_sched dut (
    .adc_clk   (adc_clk),
    .adc_reset (adc_reset),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 adc_clk = ~adc_clk;

  int cycle_n = 0;
  initial forever begin
    @(posedge adc_clk);
    cycle_n++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];      // {blank, ch, data}
  int gen = 0;
  logic [7:0] m_mask = 8'h00;
  int m_num = 0;
  int n_starts = 0, n_samples = 0, n_done = 0;
  int start_cyc[64];
  int start_ch_log[64];
  int start_dec[64];
  int smp_ch_log[64];
  int smp_data_log[64];
  int smp_blank_log[64];
  int latest_gen = -1, latest_idx = -1;

  // ---------------- core model knobs ----------------
  int conv_cyc = 8;
  bit core_hang = 1'b0;
  int dec_idx = -1;
  int force_idx = -1;
  logic [11:0] force_val = 12'h000;
  int core_start_n = 0;
  int core_cnt = 0;
  int core_cur_idx = 0;
  int core_conv_n = 0;
  logic [2:0] core_prog_ch = 3'd0;
  logic [2:0] core_applied_ch = 3'd0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Ascending enabled channels, cyclic: k-th start of a scan programs entry k.
  function automatic int nth_ch(input logic [7:0] mask, input int k);
    int list[$];
    for (int b = 0; b < 8; b++) if (mask[b]) list.push_back(b);
    if (list.size() == 0) return 0;
    return list[k % list.size()];
  endfunction

  // ---------------- LTC2308 core model ----------------
  initial begin
    bus.measure_done     = 1'b0;
    bus.measure_dataread = 12'h000;
    bus.DEC              = 1'b0;
    forever begin
      @(posedge adc_clk);
      #1;
      if (bus.measure_start) begin
        core_applied_ch  = core_prog_ch;
        core_prog_ch     = bus.measure_ch;
        core_cur_idx     = core_start_n;
        core_start_n++;
        core_cnt         = core_hang ? 0 : conv_cyc;
        bus.measure_done = 1'b0;
        bus.DEC          = (core_cur_idx == dec_idx);
      end else begin
        bus.DEC = 1'b0;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_conv_n++;
            bus.measure_dataread = (core_cur_idx == force_idx) ? force_val
                                   : {core_applied_ch, 9'(core_conv_n)};
            bus.measure_done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit done_prev = 1'b0;
  bit hold_prev = 1'b0;
  logic [15:0] hold_word = 16'h0;

  initial forever begin
    @(negedge adc_clk);
    if (adc_reset) begin
      hold_prev = 1'b0;
      done_prev = bus.measure_done;
    end else begin
      if (hold_prev) begin
        check("hold_valid", bus.smp_valid, 1);
        check("hold_word", {bus.smp_blank, bus.smp_ch, bus.smp_data}, hold_word);
      end
      if (bus.measure_start) begin
        int idx;
        idx = core_start_n - 1;
        check("start_ch", bus.measure_ch, nth_ch(m_mask, idx));
        if (m_num != 0 && idx > m_num) check("extra_start", idx, m_num);
        start_cyc[idx & 63]    = cycle_n;
        start_ch_log[idx & 63] = bus.measure_ch;
        start_dec[idx & 63]    = bus.DEC;
        latest_gen = gen;
        latest_idx = idx;
        n_starts++;
      end
      if (bus.measure_done && !done_prev && latest_gen == gen && latest_idx >= 1) begin
        logic        blank;
        logic [11:0] data;
        logic [2:0]  ch;
        blank = BLANK_EN && (start_dec[latest_idx & 63] != 0);
        data  = blank ? 12'd400 : bus.measure_dataread;
        ch    = 3'(nth_ch(m_mask, latest_idx - 1));
        exp_q.push_back({blank, ch, data});
      end
      done_prev = bus.measure_done;
      if (bus.smp_valid && bus.smp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("smp_data", bus.smp_data, e[11:0]);
          check("smp_ch", bus.smp_ch, e[14:12]);
          check("smp_blank", bus.smp_blank, e[15]);
        end
        smp_ch_log[n_samples & 63]    = bus.smp_ch;
        smp_data_log[n_samples & 63]  = bus.smp_data;
        smp_blank_log[n_samples & 63] = bus.smp_blank;
        n_samples++;
      end
      if (bus.scan_done) n_done++;
      hold_prev = bus.smp_valid && !bus.smp_ready;
      hold_word = {bus.smp_blank, bus.smp_ch, bus.smp_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [7:0] mask, input int num, input int period);
    @(posedge adc_clk);
    #1;
    gen++;
    m_mask = mask;
    m_num = num;
    core_start_n = 0;
    n_starts = 0;
    n_samples = 0;
    n_done = 0;
    bus.cfg_ch_mask  = mask;
    bus.cfg_scan_num = 12'(num);
    bus.cfg_period   = 16'(period);
    bus.cfg_start    = 1'b1;
    @(posedge adc_clk);
    #1;
    bus.cfg_start = 1'b0;
  endtask

  task automatic abort_scan(input bit with_start);
    @(posedge adc_clk);
    #1;
    gen++;
    exp_q.delete();
    bus.cfg_abort   = 1'b1;
    bus.cfg_start   = with_start;
    bus.cfg_ch_mask = 8'h01;
    @(posedge adc_clk);
    #1;
    bus.cfg_abort = 1'b0;
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_scan_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge adc_clk);
      if (bus.scan_done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_starts(input string name, input int cnt, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge adc_clk);
      if (n_starts >= cnt) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s0, d0, t0, t1;
    bit seen;
    int exp_st[5]  = '{0, 2, 0, 2, 0};
    int exp_smp[4] = '{0, 2, 0, 2};

    adc_reset        = 1'b1;
    bus.cfg_start    = 1'b0;
    bus.cfg_abort    = 1'b0;
    bus.cfg_ch_mask  = 8'h00;
    bus.cfg_period   = 16'd0;
    bus.cfg_scan_num = 12'd0;
    bus.smp_ready    = 1'b1;
    repeat (4) @(posedge adc_clk);
    #1 adc_reset = 1'b0;
    @(negedge adc_clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.smp_valid, 0);
    check("rst_start", bus.measure_start, 0);
    check("rst_ch", bus.measure_ch, 0);
    check("rst_scan_done", bus.scan_done, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_data", bus.smp_data, 0);

    // 1: two-channel scan, back-to-back, no backpressure
    conv_cyc = 8;
    launch(8'h05, 4, 0);
    wait_scan_done("t1_scan_done", 500);
    @(negedge adc_clk);
    check("t1_starts", n_starts, 5);
    check("t1_samples", n_samples, 4);
    check("t1_done_pulses", n_done, 1);
    check("t1_busy", bus.busy, 0);
    check("t1_exp_empty", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) check("t1_start_ch_lit", start_ch_log[i], exp_st[i]);
    for (int i = 0; i < 4; i++) check("t1_smp_ch_lit", smp_ch_log[i], exp_smp[i]);

    // 2: stall the first sample for 20 cycles
    bus.smp_ready = 1'b0;
    launch(8'h05, 4, 0);
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge adc_clk);
      if (bus.smp_valid) seen = 1'b1;
    end
    check("t2_first_valid", seen, 1);
    s0 = n_starts;
    repeat (20) @(negedge adc_clk);
    check("t2_stall_starts", n_starts - s0, 0);
    check("t2_still_valid", bus.smp_valid, 1);
    @(posedge adc_clk);
    #1 bus.smp_ready = 1'b1;
    wait_scan_done("t2_scan_done", 500);
    @(negedge adc_clk);
    check("t2_starts", n_starts, 5);
    check("t2_samples", n_samples, 4);

    // 3: single channel 7, 100-cycle period, 40-cycle conversions
    conv_cyc = 40;
    launch(8'h80, 3, 100);
    wait_scan_done("t3_scan_done", 800);
    @(negedge adc_clk);
    check("t3_starts", n_starts, 4);
    for (int i = 1; i < 4; i++) check("t3_spacing_lit", start_cyc[i] - start_cyc[i-1], 100);
    for (int i = 0; i < 3; i++) check("t3_smp_ch_lit", smp_ch_log[i], 7);

    // 4: conversion never completes
    core_hang = 1'b1;
    launch(8'h01, 1, 0);
    wait_starts("t4_prime", 1, 10);
    t0 = start_cyc[0];
    seen = 1'b0;
    t1 = 0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(negedge adc_clk);
      if (bus.err_timeout) begin
        seen = 1'b1;
        t1 = cycle_n;
      end
    end
    check("t4_err_seen", seen, 1);
    check("t4_err_latency", (t1 - t0 >= 1023) && (t1 - t0 <= 1025), 1);
    check("t4_busy", bus.busy, 0);
    repeat (5) @(negedge adc_clk);
    check("t4_err_sticky", bus.err_timeout, 1);
    check("t4_samples", n_samples, 0);
    check("t4_no_done", n_done, 0);
    core_hang = 1'b0;

    // 5: DEC on the second start, core returns 0xABC for that conversion
    conv_cyc  = 10;
    dec_idx   = 1;
    force_idx = 1;
    force_val = 12'hABC;
    launch(8'h02, 2, 0);
    @(negedge adc_clk);
    check("t5_err_cleared", bus.err_timeout, 0);
    wait_scan_done("t5_scan_done", 300);
    check("t5_data_lit", smp_data_log[0], BLANK_EN ? 400 : 12'hABC);
    check("t5_blank_lit", smp_blank_log[0], BLANK_EN ? 1 : 0);
    check("t5_ch_lit", smp_ch_log[0], 1);
    check("t5_blank2_lit", smp_blank_log[1], 0);
    dec_idx   = -1;
    force_idx = -1;

    // 6: abort in WAIT, let the stale result land while idle, then restart
    conv_cyc = 30;
    launch(8'h03, 0, 0);
    wait_starts("t6_second_start", 2, 100);
    repeat (5) @(negedge adc_clk);
    d0 = n_done;
    abort_scan(1'b0);
    check("t6_busy_after_abort", bus.busy, 0);
    check("t6_valid_after_abort", bus.smp_valid, 0);
    repeat (40) @(negedge adc_clk);
    check("t6_idle_busy", bus.busy, 0);
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_samples", n_samples, 0);
    launch(8'h01, 2, 0);
    wait_scan_done("t6_restart_done", 300);
    @(negedge adc_clk);
    check("t6_restart_starts", n_starts, 3);
    check("t6_restart_samples", n_samples, 2);

    // abort and start together: start dropped
    conv_cyc = 10;
    launch(8'h06, 0, 0);
    wait_starts("t7_running", 3, 100);
    s0 = n_starts;
    abort_scan(1'b1);
    repeat (3) @(negedge adc_clk);
    check("t7_busy", bus.busy, 0);
    check("t7_no_start", n_starts - s0, 0);

    // start with empty mask: one scan_done, never busy
    launch(8'h00, 4, 0);
    repeat (3) @(negedge adc_clk);
    check("t8_done_pulse", n_done, 1);
    check("t8_busy", bus.busy, 0);
    check("t8_starts", n_starts, 0);
    check("end_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
